// File: rtl/arb4_mux_ctrl_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter with registered output mux.
package arb_pkg;

    localparam int DATA_W = 8;
    localparam int N_REQ  = 4;

    typedef logic [1:0]        src_t;
    typedef logic [DATA_W-1:0] word_t;

    // The lowest offset from ptr wins, so the loop runs from the far end toward ptr.
    function automatic src_t rr_pick(input logic [3:0] valid, input src_t ptr);
        src_t idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + src_t'(k);
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/arb4_mux_ctrl_if.sv
// Requester-side and output-side handshake bundle of the arbiter.
interface arb4_mux_ctrl_if #(
    parameter int DATA_W = arb_pkg::DATA_W,
    parameter int N_REQ  = arb_pkg::N_REQ
);
    import arb_pkg::*;

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            out_data;
    src_t                         out_src;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/arb4_mux_ctrl_mux4.sv
// Plain 4:1 word multiplexer.
module MUX4 #(
    parameter int W = 8
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] y
);

    always_comb begin
        y = in0;
        case (sel)
            2'd0: y = in0;
            2'd1: y = in1;
            2'd2: y = in2;
            2'd3: y = in3;
            default: y = in0;
        endcase
    end

endmodule

// File: rtl/arb4_mux_ctrl.sv
// Round-robin arbiter over four requesters feeding a single registered output word.
module arb4_mux_ctrl #(
    parameter int DATA_W = arb_pkg::DATA_W,
    parameter int N_REQ  = arb_pkg::N_REQ
) (
    input  logic          clk,
    input  logic          rst_n,
    arb4_mux_ctrl_if.slave bus
);
    import arb_pkg::*;

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    src_t              r_out_src;
    src_t              r_ptr;

    logic [DATA_W-1:0] w_mux_out;
    src_t              w_grant;
    logic              w_load;
    logic              w_any;
    logic              w_take;
    logic [N_REQ-1:0]  w_ready;

    assign w_load  = !r_out_valid || bus.out_ready;
    assign w_any   = |bus.req_valid;
    assign w_grant = rr_pick(bus.req_valid, r_ptr);
    // rst_n gates the grant so req_ready drops the moment reset asserts, not at the next edge.
    assign w_take  = rst_n && w_load && w_any;

    always_comb begin
        w_ready = '0;
        if (w_take) w_ready[w_grant] = 1'b1;
    end

    MUX4 #(.W(DATA_W)) u_mux (
        .sel (w_grant),
        .in0 (bus.req_data[0]),
        .in1 (bus.req_data[1]),
        .in2 (bus.req_data[2]),
        .in3 (bus.req_data[3]),
        .y   (w_mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_data  <= w_mux_out;
                r_out_src   <= w_grant;
                r_out_valid <= 1'b1;
                r_ptr       <= w_grant + src_t'(1);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_arb4_mux_ctrl.sv
// Directed bench for arb4_mux_ctrl: scoreboard of expected words plus per-step grant checks.
module tb_arb4_mux_ctrl;
    import arb_pkg::*;

    typedef struct packed {
        src_t  src;
        word_t data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];
    word_t d[4];

    arb4_mux_ctrl_if bus();

    arb4_mux_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input int g);
        exp_t e;
        e.src  = src_t'(g);
        e.data = bus.req_data[g];
        sb.push_back(e);
    endtask

    // Every word consumed downstream must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $error("FAIL sb_unexpected: observed src=%0d data=%0h expected no word",
                       bus.out_src, bus.out_data);
            end else begin
                e = sb.pop_front();
                chk("sb_src", 32'(bus.out_src), 32'(e.src));
                chk("sb_data", 32'(bus.out_data), 32'(e.data));
            end
        end
    end

    initial begin
        logic [3:0] exp_r;
        int g;

        d[0] = 8'h10; d[1] = 8'h21; d[2] = 8'h32; d[3] = 8'h43;
        for (int i = 0; i < 4; i++) bus.req_data[i] = d[i];
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;

        neg(); neg();
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_data",  32'(bus.out_data),  32'h00);
        chk("reset_src",   32'(bus.out_src),   32'd0);
        chk("reset_ready", 32'(bus.req_ready), 32'b0000);

        post(); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            neg();
            g = k % 4;
            exp_r = 4'(1 << g);
            chk("rr_ready", 32'(bus.req_ready), 32'(exp_r));
            push(g);
        end

        neg();
        chk("bp_grant", 32'(bus.req_ready), 32'b0010);
        push(1);
        post(); bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("bp_data",  32'(bus.out_data),  32'h21);
            chk("bp_src",   32'(bus.out_src),   32'd1);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'b0000);
            if (k < 2) post();
        end
        post(); bus.out_ready = 1'b1;
        neg();
        chk("bp_refill", 32'(bus.req_ready), 32'b0100);
        push(2);

        post(); bus.req_valid = 4'b0010;
        neg();
        chk("wrap_grant", 32'(bus.req_ready), 32'b0010);
        push(1);
        post(); bus.req_data[2] = 8'h5A; bus.req_valid = 4'b0111;
        neg();
        chk("wrap_ptr2", 32'(bus.req_ready), 32'b0100);
        push(2);

        post(); bus.req_valid = 4'b0000;
        neg();
        chk("drain_valid1", 32'(bus.out_valid), 32'd1);
        chk("drain_ready",  32'(bus.req_ready), 32'b0000);
        post(); neg();
        chk("drain_valid0", 32'(bus.out_valid), 32'd0);
        chk("drain_hold",   32'(bus.out_data),  32'h5A);
        post(); neg();
        chk("drain_idle",   32'(bus.out_valid), 32'd0);
        post(); bus.req_data[2] = d[2]; bus.req_valid = 4'b1111;
        neg();
        chk("ptr3_grant", 32'(bus.req_ready), 32'b1000);
        push(3);

        post(); bus.req_valid = 4'b0001;
        neg();
        chk("pre_stall_grant", 32'(bus.req_ready), 32'b0001);
        push(0);
        post(); bus.out_ready = 1'b0; bus.req_valid = 4'b0011;
        neg();
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data",  32'(bus.out_data),  32'h10);
        chk("stall_ready", 32'(bus.req_ready), 32'b0000);

        #2; rst_n = 1'b0; sb.delete();
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data",  32'(bus.out_data),  32'h00);
        chk("arst_src",   32'(bus.out_src),   32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("arst_ready", 32'(bus.req_ready), 32'b0000);

        post(); rst_n = 1'b1;
        neg();
        chk("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        push(0);
        post(); bus.req_valid = 4'b0000;
        neg();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        post(); neg();
        chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
        post(); neg();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
